uart_tx_word_streamer: RTL and testbench

//  Buffers multi-byte result words from the TPU readout path in a FIFO.

---
 rtl/uart_tx_word_streamer.sv | 123 ++++++++++++
 tb/tb_uart_tx_word_streamer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_streamer.sv
// Word FIFO feeding a byte serializer that drives the UART TX byte handshake.
// Words go out least-significant byte first, back to back with no gap between words.
module uart_tx_word_streamer #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8*WORD_BYTES-1:0]       in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_count,
    output logic                          busy
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [W-1:0]    sh, sh_nx, sh_shift, head;
    logic [IW-1:0]   byte_idx, byte_idx_nx;
    logic [7:0]      tx_data_nx;
    logic            tx_valid_nx;
    logic            full, empty, push, pop, xfer, last_byte;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign push       = in_valid && !full;
    assign xfer       = tx_valid && tx_ready;
    assign last_byte  = (byte_idx == IW'(WORD_BYTES - 1));
    assign head       = mem[rd_ptr];
    assign sh_shift   = sh >> 8;
    assign in_ready   = !full;
    assign fifo_count = count;
    assign busy       = !empty || (state == S_SEND);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sh       <= '0;
            byte_idx <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            sh       <= sh_nx;
            byte_idx <= byte_idx_nx;
            tx_data  <= tx_data_nx;
            tx_valid <= tx_valid_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        sh_nx       = sh;
        byte_idx_nx = byte_idx;
        tx_data_nx  = tx_data;
        tx_valid_nx = tx_valid;
        pop         = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    sh_nx       = head;
                    byte_idx_nx = '0;
                    tx_data_nx  = head[7:0];
                    tx_valid_nx = 1'b1;
                    state_nx    = S_SEND;
                end
            end
            S_SEND: begin
                tx_valid_nx = 1'b1;
                if (xfer) begin
                    if (!last_byte) begin
                        sh_nx       = sh_shift;
                        byte_idx_nx = byte_idx + IW'(1);
                        tx_data_nx  = sh_shift[7:0];
                    end else if (!empty) begin
                        // Reload on the final-byte edge so consecutive words have no bubble.
                        pop         = 1'b1;
                        sh_nx       = head;
                        byte_idx_nx = '0;
                        tx_data_nx  = head[7:0];
                    end else begin
                        tx_valid_nx = 1'b0;
                        state_nx    = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_word_streamer.sv
// Directed bench for uart_tx_word_streamer, including a behavioural 16x-oversampled
// UART transmitter and line decoder for the end-to-end case.
module tb_uart_tx_word_streamer;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [4:0]  fifo_count;
    logic        busy;

    logic        tx_ready_drv;
    logic        use_uart;

    int unsigned checks;
    int unsigned errors;

    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q  [$];

    uart_tx_word_streamer #(.WORD_BYTES(4), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART TX model: 10-bit frame, 16 clocks per bit, not ready while shifting.
    logic       u_busy;
    logic [9:0] u_frame;
    logic [3:0] u_bit;
    logic [3:0] u_div;
    logic       line;

    assign tx_ready = use_uart ? !u_busy : tx_ready_drv;

    always @(posedge clk) begin
        if (rst) begin
            u_busy <= 1'b0;
            line   <= 1'b1;
            u_bit  <= '0;
            u_div  <= '0;
        end else if (!u_busy) begin
            if (use_uart && tx_valid && tx_ready) begin
                u_busy  <= 1'b1;
                u_frame <= {1'b1, tx_data, 1'b0};
                u_bit   <= '0;
                u_div   <= '0;
                line    <= 1'b0;
            end
        end else if (u_div == 4'd15) begin
            u_div <= '0;
            if (u_bit == 4'd9) begin
                u_busy <= 1'b0;
                line   <= 1'b1;
            end else begin
                u_bit <= u_bit + 4'd1;
                line  <= u_frame[u_bit + 4'd1];
            end
        end else begin
            u_div <= u_div + 4'd1;
        end
    end

    logic [7:0] rx_byte;
    always begin
        @(negedge line);
        repeat (8) @(posedge clk);
        if (line == 1'b0) begin
            for (int b = 0; b < 8; b++) begin
                repeat (16) @(posedge clk);
                rx_byte[b] = line;
            end
            repeat (16) @(posedge clk);
            rx_q.push_back(rx_byte);
        end
    end

    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit accept);
        in_data  = w;
        in_valid = 1'b1;
        check("in_ready", {31'd0, in_ready}, {31'd0, accept});
        tick();
        in_valid = 1'b0;
        if (accept) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        tx_ready_drv = 1'b1;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_drain_done"}, {31'd0, busy}, 32'd0);
        tx_ready_drv = 1'b0;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        logic [31:0] w6 [4];
        logic [7:0]  t3 [8];

        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        tx_ready_drv = 1'b0; use_uart = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state, latency and LSB-first order
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tx_ready_drv = 1'b1;
        push_word(32'hA1B2C3D4, 1'b1);
        exp_q.delete();
        check("t1_count_e0", {27'd0, fifo_count}, 32'd1);
        check("t1_valid_e0", {31'd0, tx_valid}, 32'd0);
        tick();
        check("t1_count_e1", {27'd0, fifo_count}, 32'd0);
        check("t1_b0", {23'd0, tx_valid, tx_data}, 32'h1D4);
        tick(); check("t1_b1", {23'd0, tx_valid, tx_data}, 32'h1C3);
        tick(); check("t1_b2", {23'd0, tx_valid, tx_data}, 32'h1B2);
        tick(); check("t1_b3", {23'd0, tx_valid, tx_data}, 32'h1A1);
        tick();
        check("t1_valid_end", {31'd0, tx_valid}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        tx_ready_drv = 1'b0;
        got_q.delete();

        // 2: fill with tx_ready low; one word sits in the serializer
        for (int i = 0; i < 16; i++) push_word(32'h1000_0000 + i, 1'b1);
        check("t2_count15", {27'd0, fifo_count}, 32'd15);
        push_word(32'h1000_0010, 1'b1);
        check("t2_count16", {27'd0, fifo_count}, 32'd16);
        push_word(32'hDEAD_BEEF, 1'b0);
        check("t2_count_full", {27'd0, fifo_count}, 32'd16);
        drain("t2");

        // 3: two queued words leave as 8 back-to-back transfers
        push_word(32'h11223344, 1'b1);
        push_word(32'h55667788, 1'b1);
        tick();
        check("t3_count", {27'd0, fifo_count}, 32'd1);
        t3 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        tx_ready_drv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_stream", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, t3[i]});
            tick();
        end
        check("t3_valid_end", {31'd0, tx_valid}, 32'd0);
        tx_ready_drv = 1'b0;
        got_q.delete();
        exp_q.delete();

        // 4: push against full FIFO on the same edge as a pop is rejected
        for (int i = 0; i < 17; i++) push_word(32'h2000_0000 + i, 1'b1);
        check("t4_full", {27'd0, fifo_count}, 32'd16);
        tx_ready_drv = 1'b1;
        tick(); tick(); tick();
        in_data  = 32'hBAD0_BAD0;
        in_valid = 1'b1;
        check("t4_in_ready_full", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        tx_ready_drv = 1'b0;
        check("t4_count_after_pop", {27'd0, fifo_count}, 32'd15);
        push_word(32'h600D_600D, 1'b1);
        check("t4_count_refill", {27'd0, fifo_count}, 32'd16);
        drain("t4");

        // 5: reset mid-word with words queued
        for (int i = 0; i < 4; i++) push_word(32'h3000_0000 + i, 1'b1);
        check("t5_count", {27'd0, fifo_count}, 32'd3);
        tx_ready_drv = 1'b1;
        tick(); tick();
        tx_ready_drv = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        check("t5_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t5_count0", {27'd0, fifo_count}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        tx_ready_drv = 1'b1;
        repeat (20) tick();
        tx_ready_drv = 1'b0;
        check("t5_no_stale", got_q.size(), 32'd0);

        // 6: end to end through the UART model and line decoder
        use_uart = 1'b1;
        rx_q.delete();
        w6 = '{32'h55555555, 32'h55AA0F55, 32'h00FF5581, 32'h5501C355};
        for (int i = 0; i < 4; i++) push_word(w6[i], 1'b1);
        n = 0;
        while (rx_q.size() < 16 && n < 5000) begin
            tick();
            n++;
        end
        check("t6_rx_len", rx_q.size(), 32'd16);
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check("t6_rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        use_uart = 1'b0;
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
